// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase fetch/decode/execute controller with memory wait states, sticky halt
// and a stall watchdog. Optional single-step gating of phase 0 via macro CPU_SEQ_STEP_EN.
module cpu_sequencer #(
    parameter int unsigned OPC_W   = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
`ifdef CPU_SEQ_STEP_EN
    input  logic             step,
`endif
    output logic             sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ac,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase,
    output logic             timeout_err
);

    localparam int unsigned PH_W  = 3;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          WDOG_EN = (TIMEOUT > 0);
    // Counter value on the last stalled cycle before the watchdog forces release
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

    typedef enum logic [PH_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    phase_t           phase_q, phase_d;
    logic             halt_q, halt_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_hlt, is_skz, is_sto, is_jmp, aluop;
    logic stall_ph, advance;

    assign is_hlt = (opcode == OP_HLT);
    assign is_skz = (opcode == OP_SKZ);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register: phase, sticky flags and stall counter
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q <= PH_INST_ADDR;
            halt_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            halt_q  <= halt_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobe decode and next-phase logic; a halted sequencer freezes with all strobes low
    always_comb begin
        phase_d  = phase_q;
        halt_d   = halt_q;
        tmo_d    = tmo_q;
        cnt_d    = '0;
        sel      = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        load_ir  = 1'b0;
        inc_pc   = 1'b0;
        load_pc  = 1'b0;
        load_ac  = 1'b0;
        data_e   = 1'b0;
        stall_ph = 1'b0;
        advance  = 1'b0;

        if (!halt_q) begin
            case (phase_q)
                PH_INST_ADDR: ;
                PH_INST_FETCH: begin
                    sel      = 1'b1;
                    mem_rd   = 1'b1;
                    stall_ph = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel     = 1'b1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt_d = is_hlt;
                end
                PH_OP_FETCH: begin
                    mem_rd   = aluop;
                    stall_ph = aluop;
                end
                PH_ALU_OP: begin
                    mem_rd  = aluop;
                    inc_pc  = is_skz & zero;
                    load_pc = is_jmp;
                    data_e  = is_sto;
                end
                PH_STORE: begin
                    mem_rd   = aluop;
                    load_ac  = aluop;
                    load_pc  = is_jmp;
                    mem_wr   = is_sto;
                    data_e   = is_sto;
                    stall_ph = is_sto;
                end
                default: ;
            endcase

            advance = 1'b1;
            if (stall_ph && !mem_ready) begin
                if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    tmo_d = 1'b1;
                end else begin
                    advance = 1'b0;
                    cnt_d   = WDOG_EN ? cnt_q + CNT_W'(1) : '0;
                end
            end

`ifdef CPU_SEQ_STEP_EN
            if ((phase_q == PH_INST_ADDR) && !step) begin
                advance = 1'b0;
            end
`endif

            if (advance) begin
                phase_d = phase_t'(phase_q + PH_W'(1));
            end
        end
    end

    assign halt        = halt_q;
    assign timeout_err = tmo_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction expected traces built from the phase
// table and stall/halt/watchdog rules, driven with directed and $urandom instructions.
module tb_cpu_sequencer;

    localparam int unsigned TMO = 15;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDO = 3'd3, XORO = 3'd4;
    localparam logic [2:0] LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic       clk, rst_, zero, mem_ready, step;
    logic [2:0] opcode;
    logic       sel, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, data_e, halt, timeout_err;
    logic [2:0] phase;
    logic       sel0, mem_rd0, mem_wr0, load_ir0, inc_pc0, load_pc0, load_ac0, data_e0, halt0, tmo0;
    logic [2:0] phase0;

    int   errors, checks;
    logic tmo_exp;

    cpu_sequencer #(.OPC_W(3), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
`ifdef CPU_SEQ_STEP_EN
        .step(step),
`endif
        .sel(sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_ac(load_ac), .data_e(data_e), .halt(halt), .phase(phase),
        .timeout_err(timeout_err)
    );

    cpu_sequencer #(.OPC_W(3), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
`ifdef CPU_SEQ_STEP_EN
        .step(step),
`endif
        .sel(sel0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .load_ir(load_ir0), .inc_pc(inc_pc0),
        .load_pc(load_pc0), .load_ac(load_ac0), .data_e(data_e0), .halt(halt0), .phase(phase0),
        .timeout_err(tmo0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: bench did not finish in time");
        $fatal(1, "time limit");
    end

    function automatic logic [12:0] cur();
        return {phase, sel, mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, data_e, halt, timeout_err};
    endfunction

    function automatic logic [12:0] cur0();
        return {phase0, sel0, mem_rd0, mem_wr0, load_ir0, inc_pc0, load_pc0, load_ac0, data_e0, halt0, tmo0};
    endfunction

    function automatic logic is_alu(input logic [2:0] op);
        return (op == ADD) || (op == ANDO) || (op == XORO) || (op == LDA);
    endfunction

    function automatic logic can_stall(input int p, input logic [2:0] op);
        return (p == 1) || (p == 5 && is_alu(op)) || (p == 7 && op == STO);
    endfunction

    // Expected strobes {sel,mem_rd,mem_wr,load_ir,inc_pc,load_pc,load_ac,data_e} from the phase table
    function automatic logic [7:0] exp_strobes(input int p, input logic [2:0] op, input logic z);
        logic s, rd, wr, ir, inc, lpc, lac, de;
        {s, rd, wr, ir, inc, lpc, lac, de} = 8'h00;
        case (p)
            1: begin s = 1'b1; rd = 1'b1; end
            2, 3: begin s = 1'b1; rd = 1'b1; ir = 1'b1; end
            4: inc = 1'b1;
            5: rd = is_alu(op);
            6: begin rd = is_alu(op); inc = (op == SKZ) & z; lpc = (op == JMP); de = (op == STO); end
            7: begin
                rd = is_alu(op); lac = is_alu(op); lpc = (op == JMP);
                wr = (op == STO); de = (op == STO);
            end
            default: ;
        endcase
        return {s, rd, wr, ir, inc, lpc, lac, de};
    endfunction

    task automatic check(input logic [12:0] obs, input logic [12:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (phase,strobes,halt,timeout_err)", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs after the edge, compare outputs on the falling edge
    task automatic tick(input logic [2:0] op, input logic z, input logic rdy,
                        input logic [2:0] eph, input logic [7:0] estb, input logic ehalt, input string tag);
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        @(negedge clk);
        check(cur(), {eph, estb, ehalt, tmo_exp}, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_ = 1'b0;
        #1;
        check(cur(), 13'h0, tag);
        @(posedge clk);
        #1;
        check(cur(), 13'h0, {tag, "_held"});
        #2;
        rst_    = 1'b1;
        tmo_exp = 1'b0;
    endtask

    // Run one instruction; sN = mem_ready-low cycles in that stall phase; abort_p < 8 resets there
    task automatic run_instr(input logic [2:0] op, input logic z, input int s1, input int s5,
                             input int s7, input int abort_p, input string tag);
        int n, cyc;
        logic rdy;
        logic [2:0] opd;
        for (int p = 0; p < 8; p++) begin
            if (p == abort_p) begin
                opcode = op;
                async_reset({tag, "_abort"});
                return;
            end
            n = 0;
            if (can_stall(p, op)) n = (p == 1) ? s1 : (p == 5) ? s5 : s7;
            cyc = (n >= int'(TMO)) ? int'(TMO) : n + 1;
            for (int c = 0; c < cyc; c++) begin
                rdy = can_stall(p, op) ? (c >= n) : 1'($urandom);
                opd = (p < 3) ? 3'($urandom) : op;
                tick(opd, z, rdy, 3'(p), exp_strobes(p, op, z), 1'b0, tag);
            end
            if (n >= int'(TMO)) tmo_exp = 1'b1;
            if (p == 4 && op == HLT) begin
                for (int c = 0; c < 20; c++)
                    tick(3'($urandom), 1'($urandom), 1'($urandom), 3'd5, 8'h00, 1'b1, {tag, "_frozen"});
                return;
            end
        end
    endtask

    initial begin
        int s1, s5, s7;
        logic [2:0] op;
        errors = 0; checks = 0; tmo_exp = 1'b0;
        rst_ = 1'b0; opcode = 3'd0; zero = 1'b0; mem_ready = 1'b1; step = 1'b1;
        #1;
        check(cur(), 13'h0, "reset_state");
        repeat (2) @(posedge clk);
        #3;
        rst_ = 1'b1;

        run_instr(LDA, 1'b0, 0, 0, 0, 8, "lda");
        run_instr(SKZ, 1'b1, 0, 0, 0, 8, "skz_z1");
        run_instr(SKZ, 1'b0, 0, 0, 0, 8, "skz_z0");
        run_instr(JMP, 1'b1, 0, 0, 0, 8, "jmp");
        run_instr(STO, 1'b0, 0, 0, 0, 8, "sto");
        run_instr(ADD, 1'b1, 0, 0, 0, 8, "add");
        run_instr(ANDO, 1'b0, 0, 0, 0, 8, "and");
        run_instr(XORO, 1'b1, 0, 0, 0, 8, "xor");
        run_instr(LDA, 1'b0, 3, 0, 0, 8, "stall_fetch3");
        run_instr(STO, 1'b0, 0, 5, 2, 8, "stall_store");
        run_instr(ADD, 1'b0, 1, 4, 6, 8, "stall_opfetch");
        run_instr(JMP, 1'b0, 0, 9, 9, 8, "no_stall_jmp");
        run_instr(LDA, 1'b0, int'(TMO) - 1, 0, 0, 8, "stall_edge");

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(7, 1));
            s1 = ($urandom_range(11, 0) == 0) ? 20 : int'($urandom_range(3, 0));
            s5 = int'($urandom_range(3, 0));
            s7 = int'($urandom_range(3, 0));
            run_instr(op, 1'($urandom), s1, s5, s7, 8, "random");
        end

        run_instr(LDA, 1'b0, 0, 0, 0, 5, "reset_mid");
        run_instr(LDA, 1'b1, 100, 0, 0, 8, "timeout_fetch");
        run_instr(LDA, 1'b0, 0, 0, 0, 8, "timeout_sticky");
        run_instr(STO, 1'b0, 0, 0, 30, 8, "timeout_store");
        run_instr(HLT, 1'b0, 2, 0, 0, 8, "halt");
        async_reset("halt_clear");

        // Watchdog disabled: mem_ready stuck low holds phase 1 indefinitely with no error
        for (int c = 0; c < 40; c++) begin
            opcode    = LDA;
            zero      = 1'b0;
            mem_ready = 1'b0;
            @(negedge clk);
            check(cur0(), {(c == 0) ? 3'd0 : 3'd1, (c == 0) ? 8'h00 : exp_strobes(1, LDA, 1'b0), 2'b00},
                  "no_watchdog");
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
